// File: rtl/tanh_lut_pipe.sv
// Two-stage tanh lookup: |bias| scaled by beta and clamped to a table index, then
// a run-time-loadable magnitude table with odd symmetry restoring the sign.
module tanh_lut_pipe #(
    parameter int IN_W   = 6,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 4,
    parameter int BETA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_bias,
    input  logic [BETA_W-1:0] beta_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_tanh,
    output logic              out_sat,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [OUT_W-2:0]  cfg_data,
    output logic              init_busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MAG_W = IN_W + 1;
    // Wide enough for the largest magnitude shifted by the largest beta.
    localparam int SC_W  = MAG_W + 2 ** BETA_W - 1;
    localparam logic [SC_W-1:0] IDX_MAX = SC_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_addr;
    logic [OUT_W-2:0]  table_mem [DEPTH];

    logic              en;
    logic [MAG_W-1:0]  bias_x, mag;
    logic [SC_W-1:0]   scaled;
    logic              sat;
    logic [ADDR_W-1:0] idx;

    logic              s1_valid, s1_sign, s1_sat;
    logic [ADDR_W-1:0] s1_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) init_addr <= init_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_addr == ADDR_W'(DEPTH - 1)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    assign init_busy = (state == S_INIT);
    assign en        = !out_valid || out_ready;
    assign in_ready  = (state == S_RUN) && en;

    // The clear sweep owns the write port until RUN; cfg writes are dropped meanwhile.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) table_mem[init_addr] <= '0;
            else if (cfg_we)     table_mem[cfg_addr]  <= cfg_data;
        end
    end

    // Extra magnitude bit so the most negative bias maps to +2**(IN_W-1).
    always_comb begin
        bias_x = {in_bias[IN_W-1], in_bias};
        mag    = in_bias[IN_W-1] ? (~bias_x + MAG_W'(1)) : bias_x;
        scaled = SC_W'(mag) << beta_shift;
        sat    = scaled > IDX_MAX;
        idx    = sat ? {ADDR_W{1'b1}} : scaled[ADDR_W-1:0];
    end

    // S2 reads the table with the pre-edge contents, so a same-cycle cfg write is seen next time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_sat    <= 1'b0;
            s1_idx    <= '0;
            out_valid <= 1'b0;
            out_tanh  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid && in_ready;
            s1_sign   <= in_bias[IN_W-1];
            s1_sat    <= sat;
            s1_idx    <= idx;
            out_valid <= s1_valid;
            out_tanh  <= {s1_sign, table_mem[s1_idx]};
            out_sat   <= s1_sat;
        end
    end
endmodule
